// File: rtl/sa_step_sequencer.sv
// Step sequencer for a systolic-array pass: walks cnt 0..LAST_STEP once per tile,
// gated by advance, then a one-cycle drain and a one-cycle done pulse.
module sa_step_sequencer #(
    parameter int CNT_W     = 4,
    parameter int LAST_STEP = 8,
    parameter int TILE_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              advance,
    input  logic              abort,
    output logic [CNT_W-1:0]  cnt,
    output logic              cnt_valid,
    output logic [TILE_W-1:0] tile_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_STEP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt_n;
    logic [TILE_W-1:0]  tile_n;
    logic [TILE_W-1:0]  last_tile, last_tile_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tile_idx  <= '0;
            last_tile <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            tile_idx  <= tile_n;
            last_tile <= last_tile_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        tile_n      = tile_idx;
        last_tile_n = last_tile;
        unique case (state)
            IDLE: begin
                // start beats a simultaneous abort; abort alone is ignored here
                if (start) begin
                    last_tile_n = (num_tiles == '0) ? '0 : num_tiles - TILE_W'(1);
                    cnt_n       = '0;
                    tile_n      = '0;
                    state_n     = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_n   = '0;
                    tile_n  = '0;
                    state_n = FINISH;
                end else if (advance) begin
                    if (cnt != LAST) begin
                        cnt_n = cnt + CNT_W'(1);
                    end else if (tile_idx != last_tile) begin
                        cnt_n  = '0;
                        tile_n = tile_idx + TILE_W'(1);
                    end else begin
                        // cnt stays parked at LAST through the drain cycle
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    cnt_n  = '0;
                    tile_n = '0;
                end
                state_n = FINISH;
            end
            FINISH: begin
                cnt_n   = '0;
                tile_n  = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign cnt_valid = (state == RUN);
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == FINISH);

endmodule

// File: tb/tb_sa_step_sequencer.sv
// Directed bench for sa_step_sequencer: single/multi-tile jobs, stalls, aborts,
// async reset mid-job, zero tile count and start/abort priority.
module tb_sa_step_sequencer;

    localparam int CNT_W  = 4;
    localparam int LAST   = 8;
    localparam int TILE_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [TILE_W-1:0] num_tiles;
    logic              advance;
    logic              abort;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_valid;
    logic [TILE_W-1:0] tile_idx;
    logic              busy;
    logic              done;

    int vectors     = 0;
    int miscompares = 0;

    sa_step_sequencer #(.CNT_W(CNT_W), .LAST_STEP(LAST), .TILE_W(TILE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_tiles (num_tiles),
        .advance   (advance),
        .abort     (abort),
        .cnt       (cnt),
        .cnt_valid (cnt_valid),
        .tile_idx  (tile_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // observed outputs packed as {cnt_valid, busy, done, tile_idx, cnt}
    wire [10:0] obs = {cnt_valid, busy, done, tile_idx, cnt};

    function automatic logic [10:0] ev(input bit v, input bit b, input bit d,
                                       input int t, input int c);
        return {v, b, d, 4'(t), 4'(c)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; num_tiles = '0; advance = 1'b0; abort = 1'b0;
        #12;
        vectors++;
        if (obs !== 11'd0) begin
            miscompares++;
            $display("FAIL reset: got %h want %h", obs, 11'd0);
        end
        #1 rst = 1'b0;
        tick();
        vectors++;
        if (obs !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_idle: got %h want %h", obs, 11'd0);
        end
    endtask

    task automatic test_single();
        start = 1'b1; num_tiles = 4'd1; advance = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= LAST; c++) begin
            vectors++;
            if (obs !== ev(1, 1, 0, 0, c)) begin
                miscompares++;
                $display("FAIL single_run c=%0d: got %h want %h", c, obs, ev(1, 1, 0, 0, c));
            end
            tick();
        end
        vectors++;
        if (obs !== ev(0, 1, 0, 0, LAST)) begin
            miscompares++;
            $display("FAIL single_drain: got %h want %h", obs, ev(0, 1, 0, 0, LAST));
        end
        tick();
        vectors++;
        if (obs !== ev(0, 0, 1, 0, LAST)) begin
            miscompares++;
            $display("FAIL single_done: got %h want %h", obs, ev(0, 0, 1, 0, LAST));
        end
        tick();
        vectors++;
        if (obs !== 11'd0) begin
            miscompares++;
            $display("FAIL single_idle: got %h want %h", obs, 11'd0);
        end
    endtask

    task automatic test_multi_tile();
        int runs = 0;
        start = 1'b1; num_tiles = 4'd3; advance = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 3; t++) begin
            for (int c = 0; c <= LAST; c++) begin
                if (cnt_valid) runs++;
                vectors++;
                if (obs !== ev(1, 1, 0, t, c)) begin
                    miscompares++;
                    $display("FAIL multi_run t=%0d c=%0d: got %h want %h", t, c, obs, ev(1, 1, 0, t, c));
                end
                tick();
            end
        end
        vectors++;
        if (runs !== 27) begin
            miscompares++;
            $display("FAIL multi_run_cycles: got %0d want 27", runs);
        end
        vectors++;
        if (obs !== ev(0, 1, 0, 2, LAST)) begin
            miscompares++;
            $display("FAIL multi_drain: got %h want %h", obs, ev(0, 1, 0, 2, LAST));
        end
        tick();
        vectors++;
        if (obs !== ev(0, 0, 1, 2, LAST)) begin
            miscompares++;
            $display("FAIL multi_done: got %h want %h", obs, ev(0, 0, 1, 2, LAST));
        end
        tick();
        vectors++;
        if (obs !== 11'd0) begin
            miscompares++;
            $display("FAIL multi_idle: got %h want %h", obs, 11'd0);
        end
    endtask

    // advance low during RUN cycles 3..5 -> cnt sits at 2 for cycles 3..6
    task automatic test_stall();
        int ec;
        start = 1'b1; num_tiles = 4'd1; advance = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            ec = (k <= 3) ? k - 1 : (k <= 6) ? 2 : k - 4;
            vectors++;
            if (obs !== ev(1, 1, 0, 0, ec)) begin
                miscompares++;
                $display("FAIL stall_run k=%0d: got %h want %h", k, obs, ev(1, 1, 0, 0, ec));
            end
            advance = !(k >= 3 && k <= 5);
            tick();
        end
        advance = 1'b1;
        vectors++;
        if (obs !== ev(0, 1, 0, 0, LAST)) begin
            miscompares++;
            $display("FAIL stall_drain: got %h want %h", obs, ev(0, 1, 0, 0, LAST));
        end
        tick();
        vectors++;
        if (obs !== ev(0, 0, 1, 0, LAST)) begin
            miscompares++;
            $display("FAIL stall_done_cycle14: got %h want %h", obs, ev(0, 0, 1, 0, LAST));
        end
        tick();
    endtask

    task automatic test_abort();
        start = 1'b1; num_tiles = 4'd2; advance = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            vectors++;
            if (obs !== ev(1, 1, 0, 0, c)) begin
                miscompares++;
                $display("FAIL abort_pre c=%0d: got %h want %h", c, obs, ev(1, 1, 0, 0, c));
            end
            if (c < 5) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (obs !== ev(0, 0, 1, 0, 0)) begin
            miscompares++;
            $display("FAIL abort_run_done: got %h want %h", obs, ev(0, 0, 1, 0, 0));
        end
        tick();
        vectors++;
        if (obs !== 11'd0) begin
            miscompares++;
            $display("FAIL abort_idle: got %h want %h", obs, 11'd0);
        end
        // abort during the drain cycle
        start = 1'b1; num_tiles = 4'd1;
        tick();
        start = 1'b0;
        repeat (LAST + 1) tick();
        vectors++;
        if (obs !== ev(0, 1, 0, 0, LAST)) begin
            miscompares++;
            $display("FAIL abort_drain_pre: got %h want %h", obs, ev(0, 1, 0, 0, LAST));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (obs !== ev(0, 0, 1, 0, 0)) begin
            miscompares++;
            $display("FAIL abort_drain_done: got %h want %h", obs, ev(0, 0, 1, 0, 0));
        end
        tick();
    endtask

    task automatic test_priority();
        abort = 1'b1;
        tick();
        vectors++;
        if (obs !== 11'd0) begin
            miscompares++;
            $display("FAIL idle_abort_ignored: got %h want %h", obs, 11'd0);
        end
        start = 1'b1; num_tiles = 4'd1;
        tick();
        start = 1'b0; abort = 1'b0;
        vectors++;
        if (obs !== ev(1, 1, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL start_beats_abort: got %h want %h", obs, ev(1, 1, 0, 0, 0));
        end
        // abort beats advance in RUN
        abort = 1'b1; advance = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (obs !== ev(0, 0, 1, 0, 0)) begin
            miscompares++;
            $display("FAIL abort_over_advance: got %h want %h", obs, ev(0, 0, 1, 0, 0));
        end
        tick();
    endtask

    task automatic test_async_reset();
        start = 1'b1; num_tiles = 4'd2; advance = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        vectors++;
        if (obs !== ev(1, 1, 0, 0, 4)) begin
            miscompares++;
            $display("FAIL rst_pre: got %h want %h", obs, ev(1, 1, 0, 0, 4));
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 11'd0) begin
            miscompares++;
            $display("FAIL rst_async: got %h want %h", obs, 11'd0);
        end
        #1 rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            vectors++;
            if (obs !== 11'd0) begin
                miscompares++;
                $display("FAIL rst_no_done k=%0d: got %h want %h", k, obs, 11'd0);
            end
        end
        start = 1'b1; num_tiles = 4'd1;
        tick();
        start = 1'b0;
        vectors++;
        if (obs !== ev(1, 1, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL rst_fresh_start: got %h want %h", obs, ev(1, 1, 0, 0, 0));
        end
        repeat (LAST + 2) tick();
        vectors++;
        if (obs !== ev(0, 0, 1, 0, LAST)) begin
            miscompares++;
            $display("FAIL rst_fresh_done: got %h want %h", obs, ev(0, 0, 1, 0, LAST));
        end
        tick();
    endtask

    // num_tiles=0 runs one pass; start held high through RUN must not restart
    task automatic test_zero_tiles();
        start = 1'b1; num_tiles = 4'd0; advance = 1'b1;
        tick();
        for (int c = 0; c <= LAST; c++) begin
            vectors++;
            if (obs !== ev(1, 1, 0, 0, c)) begin
                miscompares++;
                $display("FAIL zero_run c=%0d: got %h want %h", c, obs, ev(1, 1, 0, 0, c));
            end
            tick();
        end
        vectors++;
        if (obs !== ev(0, 1, 0, 0, LAST)) begin
            miscompares++;
            $display("FAIL zero_drain: got %h want %h", obs, ev(0, 1, 0, 0, LAST));
        end
        start = 1'b0;
        tick();
        vectors++;
        if (obs !== ev(0, 0, 1, 0, LAST)) begin
            miscompares++;
            $display("FAIL zero_done: got %h want %h", obs, ev(0, 0, 1, 0, LAST));
        end
        tick();
        vectors++;
        if (obs !== 11'd0) begin
            miscompares++;
            $display("FAIL zero_idle: got %h want %h", obs, 11'd0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_tile();
        test_stall();
        test_abort();
        test_priority();
        test_async_reset();
        test_zero_tiles();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
